// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encodings, parity codes and
// the baud divisor / parity helper functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Round to the nearest whole number of clocks per bit.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] data, input int mode);
    return (mode == PARITY_ODD) ? ~(^data) : ^data;
  endfunction

endpackage

// File: rtl/uart_tx_8n1_if.sv
// Byte handshake between on-chip producer (master) and the UART transmitter (slave).
// A byte transfers on every rising edge where tx_valid && tx_ready are both high;
// tx_ready depends only on registered state, never on tx_valid.
interface uart_tx_8n1_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered occupancy count; full/empty/level
// all come straight from the count flop.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
    $error("uart_tx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  // A full FIFO refuses writes even when a read frees a slot that same cycle.
  assign push    = wr_en & ~full;
  assign pop     = rd_en & ~empty;
  assign full    = (count_q == FULL_LVL);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_8n1.sv
// UART transmitter: FIFO-buffered bytes serialised as start, 8 data (LSB first),
// optional parity and 1-2 stop bits on a registered, idle-high txd.
module uart_tx_8n1
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                        CLK100MHZ,
  input  logic                        rstn,
  uart_tx_8n1_if.slave                tx_if,
  output logic                        txd,
  output logic                        tx_busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output state_t                      dbg_state
);
  localparam int CPB = clks_per_bit(CLK_HZ, BAUD);
  localparam int BW  = $clog2(CPB);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CPB - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);

  if (CPB < 2) begin : g_cpb_chk
    $error("uart_tx_8n1: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
    $error("uart_tx_8n1: STOP_BITS must be 1 or 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_par_chk
    $error("uart_tx_8n1: PARITY must be 0, 1 or 2");
  end

  state_t        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic          stop_q, stop_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          txd_q, txd_d;
  logic          done_q, done_d;
  logic          pop, bit_end;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rd_data;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk     (CLK100MHZ),
    .rstn    (rstn),
    .wr_en   (tx_if.tx_valid),
    .wr_data (tx_if.tx_data),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign bit_end        = (baud_q == BAUD_LAST);
  assign tx_if.tx_ready = ~fifo_full;
  assign tx_busy        = (state_q != ST_IDLE) | ~fifo_empty;
  assign txd            = txd_q;
  assign tx_done        = done_q;
  assign dbg_state      = state_q;

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_rd_data;
          par_d   = parity_bit(fifo_rd_data, PARITY);
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          bit_d   = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            stop_d  = 1'b0;
            state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          stop_d  = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // txd and tx_done are registered from the current state, so the line
  // lags the FSM by one clock and the done pulse lines up with the last stop cycle.
  always_comb begin
    txd_d = 1'b1;
    unique case (state_q)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_q[0];
      ST_PARITY: txd_d = par_q;
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK100MHZ or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      txd_q   <= txd_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Directed bench for uart_tx_8n1: four instances covering no parity, odd parity,
// even parity with two stop bits, and the default 115200 baud divisor.
`define CHK(tag, obs, exp) begin tests++; assert ((obs) === (exp)) else begin fails++; $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); end end

module tb_uart_tx_8n1;
  import uart_pkg::*;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   cyc  = 0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_8n1_if if0 ();
  uart_tx_8n1_if if1 ();
  uart_tx_8n1_if if2 ();
  uart_tx_8n1_if if3 ();

  logic       txd0, txd1, txd2, txd3;
  logic       busy0, busy1, busy2, busy3;
  logic       done0, done1, done2, done3;
  logic [4:0] lvl0, lvl1, lvl2, lvl3;
  state_t     st0, st1, st2, st3;

  uart_tx_8n1 #(.CLK_HZ(100_000_000), .BAUD(10_000_000), .FIFO_DEPTH(16), .PARITY(0), .STOP_BITS(1)) u0 (
    .CLK100MHZ(clk), .rstn(rstn), .tx_if(if0), .txd(txd0), .tx_busy(busy0),
    .tx_done(done0), .fifo_level(lvl0), .dbg_state(st0));
  uart_tx_8n1 #(.CLK_HZ(100_000_000), .BAUD(10_000_000), .FIFO_DEPTH(16), .PARITY(1), .STOP_BITS(1)) u1 (
    .CLK100MHZ(clk), .rstn(rstn), .tx_if(if1), .txd(txd1), .tx_busy(busy1),
    .tx_done(done1), .fifo_level(lvl1), .dbg_state(st1));
  uart_tx_8n1 #(.CLK_HZ(100_000_000), .BAUD(10_000_000), .FIFO_DEPTH(16), .PARITY(2), .STOP_BITS(2)) u2 (
    .CLK100MHZ(clk), .rstn(rstn), .tx_if(if2), .txd(txd2), .tx_busy(busy2),
    .tx_done(done2), .fifo_level(lvl2), .dbg_state(st2));
  uart_tx_8n1 u3 (
    .CLK100MHZ(clk), .rstn(rstn), .tx_if(if3), .txd(txd3), .tx_busy(busy3),
    .tx_done(done3), .fifo_level(lvl3), .dbg_state(st3));

  // Advance to 1 ns after the edge that makes cyc reach target.
  task automatic wait_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Frame monitor for u0 (8N1, 10 clocks per bit)
  logic       mon_en = 1'b0;
  logic [7:0] rx_q[$];
  int         st_q[$];
  int         stop_err = 0;
  logic [7:0] exp_q[$];

  initial begin
    logic [7:0] b;
    int         st;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && rstn && txd0 === 1'b0) begin
        st = cyc;
        for (int i = 0; i < 8; i++) begin
          wait_to(st + 15 + 10 * i);
          b[i] = txd0;
        end
        wait_to(st + 95);
        if (txd0 !== 1'b1) stop_err++;
        wait_to(st + 99);
        rx_q.push_back(b);
        st_q.push_back(st);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n, n0, acc, guard, bad;
    logic [7:0] b55, b30, ba5, b31, rxb;
    b55 = 8'h55;
    b30 = 8'h30;
    ba5 = 8'hA5;
    rxb = 8'h00;
    b31 = 8'h31;
    n0  = 0;
    if0.tx_valid = 1'b0; if0.tx_data = '0;
    if1.tx_valid = 1'b0; if1.tx_data = '0;
    if2.tx_valid = 1'b0; if2.tx_data = '0;
    if3.tx_valid = 1'b0; if3.tx_data = '0;

    // Reset state
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    `CHK("rst_txd0", txd0, 1'b1)
    `CHK("rst_ready0", if0.tx_ready, 1'b1)
    `CHK("rst_busy0", busy0, 1'b0)
    `CHK("rst_done0", done0, 1'b0)
    `CHK("rst_level0", lvl0, 5'd0)
    `CHK("rst_state0", st0, ST_IDLE)
    `CHK("rst_txd123", {txd1, txd2, txd3}, 3'b111)
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single 0x55 frame: latency, bit timing, done pulse
    if0.tx_data = 8'h55; if0.tx_valid = 1'b1;
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
    n = cyc;
    `CHK("t1_level_push", lvl0, 5'd1)
    wait_to(n + 1);
    `CHK("t1_txd_n1", txd0, 1'b1)
    `CHK("t1_state_n1", st0, ST_START)
    `CHK("t1_level_pop", lvl0, 5'd0)
    wait_to(n + 2);
    `CHK("t1_start_first", txd0, 1'b0)
    wait_to(n + 11);
    `CHK("t1_start_last", txd0, 1'b0)
    for (int i = 0; i < 8; i++) begin
      wait_to(n + 17 + 10 * i);
      `CHK("t1_data_bit", txd0, b55[i])
    end
    wait_to(n + 96);
    `CHK("t1_stop", txd0, 1'b1)
    `CHK("t1_busy_mid", busy0, 1'b1)
    wait_to(n + 100);
    `CHK("t1_done_early", done0, 1'b0)
    wait_to(n + 101);
    `CHK("t1_done", done0, 1'b1)
    `CHK("t1_busy_end", busy0, 1'b0)
    wait_to(n + 102);
    `CHK("t1_done_one_cycle", done0, 1'b0)
    `CHK("t1_idle_txd", txd0, 1'b1)

    // 0x30 with odd parity / 1 stop (u1) and even parity / 2 stop (u2)
    if1.tx_data = 8'h30; if1.tx_valid = 1'b1;
    if2.tx_data = 8'h30; if2.tx_valid = 1'b1;
    @(posedge clk); #1;
    if1.tx_valid = 1'b0;
    if2.tx_valid = 1'b0;
    n = cyc;
    wait_to(n + 2);
    `CHK("t2_start_u1", txd1, 1'b0)
    `CHK("t2_start_u2", txd2, 1'b0)
    for (int i = 0; i < 8; i++) begin
      wait_to(n + 17 + 10 * i);
      `CHK("t2_data_u1", txd1, b30[i])
      `CHK("t2_data_u2", txd2, b30[i])
    end
    wait_to(n + 97);
    `CHK("t2_parity_odd", txd1, 1'b1)
    `CHK("t2_parity_even", txd2, 1'b0)
    wait_to(n + 107);
    `CHK("t2_stop_u1", txd1, 1'b1)
    `CHK("t2_stop1_u2", txd2, 1'b1)
    wait_to(n + 110);
    `CHK("t2_done_early_u1", done1, 1'b0)
    wait_to(n + 111);
    `CHK("t2_done_u1", done1, 1'b1)
    `CHK("t2_done_early_u2", done2, 1'b0)
    wait_to(n + 117);
    `CHK("t2_stop2_u2", txd2, 1'b1)
    wait_to(n + 120);
    `CHK("t2_done_early2_u2", done2, 1'b0)
    wait_to(n + 121);
    `CHK("t2_done_u2", done2, 1'b1)
    wait_to(n + 122);
    `CHK("t2_busy_end_u2", busy2, 1'b0)

    // 17 bytes at one per clock, then a byte held while full across a pop
    mon_en = 1'b1;
    acc = 0;
    for (int k = 0; k < 17; k++) begin
      if0.tx_data  = 8'(k);
      if0.tx_valid = 1'b1;
      exp_q.push_back(8'(k));
      if (if0.tx_ready === 1'b1) acc++;
      @(posedge clk); #1;
      if (k == 0) n0 = cyc;
    end
    `CHK("t3_accepted", acc, 17)
    `CHK("t3_level_full", lvl0, 5'd16)
    `CHK("t3_ready_full", if0.tx_ready, 1'b0)
    if0.tx_data = 8'h11;
    exp_q.push_back(8'h11);
    guard = 0;
    while (if0.tx_ready !== 1'b1 && guard < 300) begin
      @(posedge clk); #1;
      guard++;
    end
    `CHK("t4_pop_edge", cyc, n0 + 102)
    `CHK("t4_full_pop_level", lvl0, 5'd15)
    @(posedge clk); #1;
    if0.tx_valid = 1'b0;
    `CHK("t4_level_after_accept", lvl0, 5'd16)
    while (rx_q.size() < 18 && cyc < n0 + 2600) begin
      @(posedge clk); #1;
    end
    `CHK("t3_frame_count", rx_q.size(), 18)
    if (rx_q.size() > 0) begin
      `CHK("t3_first_start", st_q[0], n0 + 2)
    end
    for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) begin
      `CHK("t3_byte", rx_q[i], exp_q[i])
    end
    for (int i = 1; i < st_q.size(); i++) begin
      `CHK("t3_frame_gap", st_q[i] - st_q[i-1], 101)
    end
    `CHK("t3_stop_errors", stop_err, 0)
    mon_en = 1'b0;
    wait_to(cyc + 5);
    `CHK("t3_busy_end", busy0, 1'b0)

    // Reset during bit 4 of 0xA5 with 3 bytes queued
    for (int k = 0; k < 4; k++) begin
      if0.tx_data  = (k == 0) ? 8'hA5 : 8'(k);
      if0.tx_valid = 1'b1;
      @(posedge clk); #1;
      if (k == 0) n = cyc;
    end
    if0.tx_valid = 1'b0;
    wait_to(n + 55);
    `CHK("t5_bit4", txd0, ba5[4])
    `CHK("t5_level_before", lvl0, 5'd3)
    rstn = 1'b0;
    #1;
    `CHK("t5_txd", txd0, 1'b1)
    `CHK("t5_level", lvl0, 5'd0)
    `CHK("t5_busy", busy0, 1'b0)
    `CHK("t5_done", done0, 1'b0)
    `CHK("t5_state", st0, ST_IDLE)
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    bad = 0;
    repeat (200) begin
      @(posedge clk); #1;
      if (txd0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) bad++;
    end
    `CHK("t5_quiet_after_reset", bad, 0)
    `CHK("t5_level_after", lvl0, 5'd0)

    // Default parameters: 868 clocks per bit, decode 0x31
    if3.tx_data = 8'h31; if3.tx_valid = 1'b1;
    @(posedge clk); #1;
    if3.tx_valid = 1'b0;
    n = cyc;
    wait_to(n + 1);
    `CHK("t6_txd_n1", txd3, 1'b1)
    wait_to(n + 2);
    `CHK("t6_start", txd3, 1'b0)
    wait_to(n + 869);
    `CHK("t6_start_last", txd3, 1'b0)
    wait_to(n + 870);
    `CHK("t6_bit0_first", txd3, b31[0])
    for (int i = 0; i < 8; i++) begin
      wait_to(n + 2 + 868 * (i + 1) + 434);
      rxb[i] = txd3;
    end
    `CHK("t6_decoded", rxb, 8'h31)
    wait_to(n + 2 + 868 * 9 + 434);
    `CHK("t6_stop", txd3, 1'b1)
    wait_to(n + 8680);
    `CHK("t6_done_early", done3, 1'b0)
    wait_to(n + 8681);
    `CHK("t6_done", done3, 1'b1)

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
